axi_wr_arbiter: RTL and testbench
=================================

Name: axi_wr_arbiter

Overview:
- Two-master to one-slave arbiter for the AXI3 write path (AW, W, B channels).
- Grants one master at a time, round-robin, and owns the slave write path for the whole transaction: address, all W beats, then the B response.
- Regenerates WLAST from AWLEN and flags masters whose WLAST disagrees with the beat count.
- Sits between the master agents on the write side and the single slave port of the AXI bus.

Parameters:
ID_W  4  width of AWID/WID/BID
ADDR_W  32  width of AWADDR
DATA_W  32  width of WDATA; WSTRB width = DATA_W/8
LEN_W  4  width of AWLEN (AXI3 burst length, beats = AWLEN+1)

Ports:
clk  input  1  clock, all logic on posedge
rstn  input  1  asynchronous active-low reset
mN_awid, mN_awaddr, mN_awlen, mN_awsize[3], mN_awburst[2] (N=0,1)  input  per param  master AW payload
mN_awvalid  input  1  master AW valid
mN_awready  output  1  master AW ready
mN_wid, mN_wdata, mN_wstrb, mN_wlast  input  per param  master W payload
mN_wvalid  input  1  master W valid
mN_wready  output  1  master W ready
mN_bid[ID_W], mN_bresp[2]  output  per param  routed B payload
mN_bvalid  output  1  routed B valid
mN_bready  input  1  master B ready
s_awid, s_awaddr, s_awlen, s_awsize, s_awburst  output  per param  muxed AW payload
s_awvalid  output  1  slave AW valid
s_awready  input  1  slave AW ready
s_wid, s_wdata, s_wstrb  output  per param  muxed W payload
s_wlast  output  1  regenerated WLAST
s_wvalid  output  1  slave W valid
s_wready  input  1  slave W ready
s_bid, s_bresp  input  per param  slave B payload
s_bvalid  input  1  slave B valid
s_bready  output  1  slave B ready
grant  output  1  currently/last granted master index
busy  output  1  state != IDLE
err_wlast  output  1  one-cycle pulse: master WLAST mismatch

Behaviour:
- Async reset (rstn low, immediate): state=IDLE, last_grant=1 (so m0 wins the first tie), grant=0, beat_cnt=0, err_wlast=0. All valid and ready outputs are 0 while in reset.
- States: IDLE, AW, W, B.
- IDLE:
  - If any mN_awvalid is high, register grant: a lone requester wins; on a tie, the master != last_grant wins.
  - Next state AW. Grant takes one cycle; there is no AW pass-through while in IDLE.
- AW:
  - s_aw* payload = granted master's payload; s_awvalid = granted mN_awvalid.
  - Granted mN_awready = s_awready; the other master's awready = 0.
  - On s_awvalid & s_awready: latch awlen into len_q, set beat_cnt=0, go to W.
  - The slave holding s_awready low stalls indefinitely; the payload is passed through unchanged.
- W:
  - s_w* payload = granted master's; s_wvalid = granted mN_wvalid; granted mN_wready = s_wready; the other master's wready = 0.
  - s_wlast = (beat_cnt == len_q). The master's mN_wlast is not forwarded.
  - On each beat handshake:
    - if mN_wlast != (beat_cnt == len_q), pulse err_wlast the next cycle;
    - if beat_cnt == len_q, go to B; otherwise beat_cnt += 1 (LEN_W bits, never wraps, since exit is at len_q).
  - W data offered by a master before its AW is granted is held off (wready=0).
- B:
  - Granted mN_bvalid = s_bvalid; mN_bid/mN_bresp = s_bid/s_bresp. The other master's bvalid = 0 and its bid/bresp = 0.
  - s_bready = granted mN_bready.
  - On handshake: last_grant = grant, go to IDLE.
- Only one transaction is outstanding at a time. Minimum transaction = 1 (IDLE) + 1 (AW) + (AWLEN+1) beats + 1 (B) cycles.
- The non-granted master's AW request stays pending (valid held by the master) until the arbiter returns to IDLE.
- grant holds its value between transactions. busy = (state != IDLE).
- Reset asserted mid-operation aborts the transaction: outputs drop asynchronously and state returns to IDLE. No recovery of the partial burst.

Test Plan:
- m0 alone, AWADDR=0x1000, AWLEN=3 -> s_awvalid then 4 W beats, s_wlast on 4th only; s_bresp=0 routed to m0_bvalid; m1_bvalid=0; err_wlast=0.
- m0 and m1 both raise AWVALID after reset, AWLEN=0 each -> m0 served fully first, then m1; repeat tie -> m0 again (last_grant=m1), i.e. strict alternation.
- m0 AWLEN=3 with mN_wlast high on beat 2 -> err_wlast pulse after beat 2; s_wlast high only on beat 4; state reaches B after 4 beats.
- s_awready held low 5 cycles during m1 AW -> s_awvalid=1 and s_awaddr stable all 5 cycles; m0_awready=0; m1_awready rises with s_awready.
- rstn pulled low during W beat 2 -> s_wvalid, s_awvalid, s_bready, all mN ready/valid outputs 0 immediately; busy=0. After release, a tie grants m0.
- AWLEN=0 with s_bvalid high and m1_bready low for 3 cycles -> s_bready=0 and state stays B for 3 cycles; handshake on cycle 4, then IDLE.

Source files
------------

// File: rtl/axi_wr_arbiter.sv
`default_nettype none
// ============================================================================
// axi_wr_arbiter : two-master round-robin arbiter for the AXI3 write path.
//   The granted master owns AW, every W beat and B; WLAST is regenerated.
// Revision: 1.0
// ============================================================================
module axi_wr_arbiter #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic                clk,
  input  logic                rstn,
  // master 0 write side
  input  logic [ID_W-1:0]     m0_awid,
  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic [LEN_W-1:0]    m0_awlen,
  input  logic [2:0]          m0_awsize,
  input  logic [1:0]          m0_awburst,
  input  logic                m0_awvalid,
  output logic                m0_awready,
  input  logic [ID_W-1:0]     m0_wid,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic                m0_wlast,
  input  logic                m0_wvalid,
  output logic                m0_wready,
  output logic [ID_W-1:0]     m0_bid,
  output logic [1:0]          m0_bresp,
  output logic                m0_bvalid,
  input  logic                m0_bready,
  // master 1 write side
  input  logic [ID_W-1:0]     m1_awid,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic [LEN_W-1:0]    m1_awlen,
  input  logic [2:0]          m1_awsize,
  input  logic [1:0]          m1_awburst,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [ID_W-1:0]     m1_wid,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wlast,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  output logic [ID_W-1:0]     m1_bid,
  output logic [1:0]          m1_bresp,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  // slave write port
  output logic [ID_W-1:0]     s_awid,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic [LEN_W-1:0]    s_awlen,
  output logic [2:0]          s_awsize,
  output logic [1:0]          s_awburst,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [ID_W-1:0]     s_wid,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wlast,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic [ID_W-1:0]     s_bid,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid,
  output logic                s_bready,
  // status
  output logic                grant,
  output logic                busy,
  output logic                err_wlast
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AW   = 2'd1,
    S_W    = 2'd2,
    S_B    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_grant;
  logic             w_grant_nxt;
  logic             r_last_grant;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_beat;
  logic             r_err;

  logic w_in_aw, w_in_w, w_in_b;
  logic w_aw_hs, w_w_hs, w_b_hs;
  logic w_last_beat, w_mwlast;

  assign w_in_aw     = (r_state == S_AW);
  assign w_in_w      = (r_state == S_W);
  assign w_in_b      = (r_state == S_B);
  assign w_last_beat = (r_beat == r_len);
  assign w_mwlast    = r_grant ? m1_wlast : m0_wlast;

  assign w_aw_hs = s_awvalid & s_awready;
  assign w_w_hs  = s_wvalid & s_wready;
  assign w_b_hs  = s_bvalid & s_bready;

  always_comb begin
    w_next      = r_state;
    w_grant_nxt = r_grant;
    case (r_state)
      S_IDLE: begin
        if (m0_awvalid | m1_awvalid) begin
          w_next = S_AW;
          // On a tie the master not served last time wins
          if (m0_awvalid & m1_awvalid) w_grant_nxt = ~r_last_grant;
          else                         w_grant_nxt = m1_awvalid;
        end
      end
      S_AW:    if (w_aw_hs) w_next = S_W;
      S_W:     if (w_w_hs && w_last_beat) w_next = S_B;
      S_B:     if (w_b_hs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_len        <= '0;
      r_beat       <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next;
      r_grant <= w_grant_nxt;
      r_err   <= w_w_hs & (w_mwlast != w_last_beat);
      if (w_aw_hs) begin
        r_len  <= r_grant ? m1_awlen : m0_awlen;
        r_beat <= '0;
      end else if (w_w_hs && !w_last_beat) begin
        r_beat <= r_beat + 1'b1;
      end
      if (w_b_hs) r_last_grant <= r_grant;
    end
  end

  // Payloads are muxed freely; only valid/ready are qualified by state
  assign s_awid    = r_grant ? m1_awid    : m0_awid;
  assign s_awaddr  = r_grant ? m1_awaddr  : m0_awaddr;
  assign s_awlen   = r_grant ? m1_awlen   : m0_awlen;
  assign s_awsize  = r_grant ? m1_awsize  : m0_awsize;
  assign s_awburst = r_grant ? m1_awburst : m0_awburst;
  assign s_awvalid = w_in_aw & (r_grant ? m1_awvalid : m0_awvalid);
  assign m0_awready = w_in_aw & ~r_grant & s_awready;
  assign m1_awready = w_in_aw &  r_grant & s_awready;

  assign s_wid     = r_grant ? m1_wid   : m0_wid;
  assign s_wdata   = r_grant ? m1_wdata : m0_wdata;
  assign s_wstrb   = r_grant ? m1_wstrb : m0_wstrb;
  assign s_wlast   = w_in_w & w_last_beat;
  assign s_wvalid  = w_in_w & (r_grant ? m1_wvalid : m0_wvalid);
  assign m0_wready = w_in_w & ~r_grant & s_wready;
  assign m1_wready = w_in_w &  r_grant & s_wready;

  assign s_bready  = w_in_b & (r_grant ? m1_bready : m0_bready);
  assign m0_bvalid = w_in_b & ~r_grant & s_bvalid;
  assign m1_bvalid = w_in_b &  r_grant & s_bvalid;
  assign m0_bid    = (w_in_b & ~r_grant) ? s_bid   : '0;
  assign m0_bresp  = (w_in_b & ~r_grant) ? s_bresp : 2'b00;
  assign m1_bid    = (w_in_b &  r_grant) ? s_bid   : '0;
  assign m1_bresp  = (w_in_b &  r_grant) ? s_bresp : 2'b00;

  assign grant     = r_grant;
  assign busy      = (r_state != S_IDLE);
  assign err_wlast = r_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_axi_wr_arbiter : directed self-checking bench for axi_wr_arbiter.
// Revision: 1.0
// ============================================================================
module tb_axi_wr_arbiter;

  logic        clk;
  logic        rstn;
  logic [3:0]  m_awid    [2];
  logic [31:0] m_awaddr  [2];
  logic [3:0]  m_awlen   [2];
  logic [2:0]  m_awsize  [2];
  logic [1:0]  m_awburst [2];
  logic        m_awvalid [2];
  logic        m_awready [2];
  logic [3:0]  m_wid     [2];
  logic [31:0] m_wdata   [2];
  logic [3:0]  m_wstrb   [2];
  logic        m_wlast   [2];
  logic        m_wvalid  [2];
  logic        m_wready  [2];
  logic [3:0]  m_bid     [2];
  logic [1:0]  m_bresp   [2];
  logic        m_bvalid  [2];
  logic        m_bready  [2];

  logic [3:0]  s_awid;
  logic [31:0] s_awaddr;
  logic [3:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst;
  logic        s_awvalid, s_awready;
  logic [3:0]  s_wid;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wlast, s_wvalid, s_wready;
  logic [3:0]  s_bid;
  logic [1:0]  s_bresp;
  logic        s_bvalid, s_bready;
  logic        grant, busy, err_wlast;

  int errors = 0;
  int checks = 0;

  axi_wr_arbiter dut (
    .clk(clk), .rstn(rstn),
    .m0_awid(m_awid[0]), .m0_awaddr(m_awaddr[0]), .m0_awlen(m_awlen[0]),
    .m0_awsize(m_awsize[0]), .m0_awburst(m_awburst[0]),
    .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]),
    .m0_wid(m_wid[0]), .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]),
    .m0_wlast(m_wlast[0]), .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]),
    .m0_bid(m_bid[0]), .m0_bresp(m_bresp[0]), .m0_bvalid(m_bvalid[0]),
    .m0_bready(m_bready[0]),
    .m1_awid(m_awid[1]), .m1_awaddr(m_awaddr[1]), .m1_awlen(m_awlen[1]),
    .m1_awsize(m_awsize[1]), .m1_awburst(m_awburst[1]),
    .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]),
    .m1_wid(m_wid[1]), .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]),
    .m1_wlast(m_wlast[1]), .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]),
    .m1_bid(m_bid[1]), .m1_bresp(m_bresp[1]), .m1_bvalid(m_bvalid[1]),
    .m1_bready(m_bready[1]),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .grant(grant), .busy(busy), .err_wlast(err_wlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_err", err_wlast, 0);
    chk("rst_s_awvalid", s_awvalid, 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  task automatic req(input int m, input logic [31:0] addr, input logic [3:0] len);
    m_awid[m]    = (m == 0) ? 4'h3 : 4'hC;
    m_awaddr[m]  = addr;
    m_awlen[m]   = len;
    m_awvalid[m] = 1'b1;
  endtask

  // Called right after the AW handshake edge: drives all W beats then B.
  task automatic serve_wb(input int m, input int len, input int bad,
                          input logic [1:0] bresp, input logic [3:0] bid);
    m_awvalid[m] = 1'b0;
    for (int i = 0; i <= len; i++) begin
      m_wid[m]    = m_awid[m];
      m_wdata[m]  = 32'hD000_0000 | (m << 8) | i;
      m_wstrb[m]  = 4'hF;
      m_wlast[m]  = (i == len) ^ (i == bad);
      m_wvalid[m] = 1'b1;
      #1;
      chk("w_valid", s_wvalid, 1);
      chk("w_data", s_wdata, 32'hD000_0000 | (m << 8) | i);
      chk("w_last", s_wlast, (i == len));
      chk("w_ready_g", m_wready[m], 1);
      chk("w_ready_o", m_wready[1-m], 0);
      chk("w_err", err_wlast, (i - 1 == bad));
      tick();
    end
    m_wvalid[m] = 1'b0;
    #1;
    chk("b_busy", busy, 1);
    chk("b_err", err_wlast, (len == bad));
    chk("b_s_wvalid", s_wvalid, 0);
    s_bvalid    = 1'b1;
    s_bresp     = bresp;
    s_bid       = bid;
    m_bready[m] = 1'b1;
    #1;
    chk("b_valid_g", m_bvalid[m], 1);
    chk("b_valid_o", m_bvalid[1-m], 0);
    chk("b_resp", m_bresp[m], bresp);
    chk("b_id", m_bid[m], bid);
    chk("b_id_o", m_bid[1-m], 0);
    chk("b_sready", s_bready, 1);
    tick();
    s_bvalid    = 1'b0;
    m_bready[m] = 1'b0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_err", err_wlast, 0);
  endtask

  task automatic serve(input int m, input int bad, input logic [1:0] bresp);
    #1;
    chk("idle_no_pass", s_awvalid, 0);
    chk("idle_awready", m_awready[m], 0);
    tick();
    chk("aw_grant", grant, m);
    chk("aw_busy", busy, 1);
    chk("aw_valid", s_awvalid, 1);
    chk("aw_addr", s_awaddr, m_awaddr[m]);
    chk("aw_len", s_awlen, m_awlen[m]);
    chk("aw_id", s_awid, m_awid[m]);
    chk("aw_ready_g", m_awready[m], 1);
    chk("aw_ready_o", m_awready[1-m], 0);
    tick();
    serve_wb(m, int'(m_awlen[m]), bad, bresp, m_awid[m]);
  endtask

  initial begin
    rstn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_awid[k] = '0; m_awaddr[k] = '0; m_awlen[k] = '0;
      m_awsize[k] = 3'd2; m_awburst[k] = 2'd1; m_awvalid[k] = 1'b0;
      m_wid[k] = '0; m_wdata[k] = '0; m_wstrb[k] = '0;
      m_wlast[k] = 1'b0; m_wvalid[k] = 1'b0; m_bready[k] = 1'b0;
    end
    s_awready = 1'b1; s_wready = 1'b1;
    s_bid = '0; s_bresp = '0; s_bvalid = 1'b0;

    // Reset state and m0 alone, 4-beat burst
    do_reset();
    req(0, 32'h1000, 4'd3);
    serve(0, 99, 2'b00);

    // Tie after reset: m0, then m1, then m0 again
    do_reset();
    req(0, 32'h0A0, 4'd0);
    req(1, 32'h0B0, 4'd0);
    serve(0, 99, 2'b00);
    req(0, 32'h0A4, 4'd0);
    serve(1, 99, 2'b10);
    serve(0, 99, 2'b01);

    // Early WLAST on beat 2
    req(0, 32'h3000, 4'd3);
    serve(0, 1, 2'b00);

    // Slave stalls AW for 5 cycles during m1 request
    req(1, 32'h4000, 4'd1);
    s_awready = 1'b0;
    #1;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", s_awvalid, 1);
      chk("stall_addr", s_awaddr, 32'h4000);
      chk("stall_m0_rdy", m_awready[0], 0);
      chk("stall_m1_rdy", m_awready[1], 0);
      tick();
    end
    s_awready = 1'b1;
    #1;
    chk("stall_release", m_awready[1], 1);
    tick();
    serve_wb(1, 1, 99, 2'b11, 4'h7);

    // Reset asserted during W beat 2
    req(0, 32'h5000, 4'd3);
    #1;
    tick();
    tick();
    m_awvalid[0] = 1'b0;
    m_wvalid[0]  = 1'b1;
    m_wlast[0]   = 1'b0;
    tick();
    #1;
    chk("pre_rst_wvalid", s_wvalid, 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_wvalid", s_wvalid, 0);
    chk("mid_rst_awvalid", s_awvalid, 0);
    chk("mid_rst_bready", s_bready, 0);
    chk("mid_rst_wready", m_wready[0], 0);
    chk("mid_rst_awready", m_awready[0], 0);
    chk("mid_rst_bvalid", m_bvalid[0], 0);
    chk("mid_rst_busy", busy, 0);
    m_wvalid[0] = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    tick();
    req(0, 32'h6000, 4'd0);
    req(1, 32'h7000, 4'd0);
    serve(0, 99, 2'b00);

    // m1 (pending) with B backpressure for 3 cycles
    #1;
    tick();
    chk("bp_grant", grant, 1);
    tick();
    m_awvalid[1] = 1'b0;
    m_wvalid[1]  = 1'b1;
    m_wlast[1]   = 1'b1;
    tick();
    m_wvalid[1]  = 1'b0;
    s_bvalid     = 1'b1;
    m_bready[1]  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_sready", s_bready, 0);
      chk("bp_busy", busy, 1);
      chk("bp_bvalid", m_bvalid[1], 1);
      tick();
    end
    m_bready[1] = 1'b1;
    #1;
    chk("bp_hs", s_bready, 1);
    tick();
    s_bvalid    = 1'b0;
    m_bready[1] = 1'b0;
    #1;
    chk("bp_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
